reg_arbiter_rr: RTL and testbench

- Shares one register_interface target among NUM_REQ register_interface requesters.
- Arbitration is round-robin. A grant is locked for the whole transaction (valid until ready).
- An optional timeout counter completes stalled transactions with an error.
- Sits between several reg masters (e.g. multiple OBI/AXI-to-reg bridges) and one peripheral register file.

---
 rtl/reg_arbiter_pkg.sv | 26 ++
 rtl/reg_arbiter_rr_pick.sv | 31 +++
 rtl/reg_arbiter_rr.sv | 110 +++++++++++
 tb/tb_reg_arbiter_rr.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/reg_arbiter_pkg.sv
// reg_arbiter_pkg: shared types and helpers for the register-interface arbiters.
// Provides the arbiter FSM state enum, default register_interface request and
// response structs, and a wrap-around increment used for round-robin pointers.
package reg_arbiter_pkg;

   typedef enum logic {IDLE, LOCKED} state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } req_default_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } rsp_default_t;

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/reg_arbiter_rr_pick.sv
// reg_arbiter_rr_pick: combinational rotating-priority finder.
// Ports: valid_i (request vector), rr_i (highest-priority index),
//        any_valid_o (some request pending), idx_o (first valid index at or after rr_i, wrapping).
module reg_arbiter_rr_pick #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0]   valid_i,
   input  logic [IDX_WIDTH-1:0] rr_i,
   output logic                 any_valid_o,
   output logic [IDX_WIDTH-1:0] idx_o
);

   logic [IDX_WIDTH-1:0] j;
   logic                 found;

   always_comb begin
      any_valid_o = |valid_i;
      idx_o       = '0;
      found       = 1'b0;
      j           = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         j = IDX_WIDTH'((32'(rr_i) + k) % NUM_REQ);
         if (valid_i[j] && !found) begin
            idx_o = j;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_arbiter_rr.sv
// reg_arbiter_rr: round-robin arbiter sharing one register_interface target among NUM_REQ requesters.
// Ports: clk_i, rst_ni (async, active-low); req_i/rsp_o requester side; req_o/rsp_i target side;
//        gnt_idx_o current owner (valid with busy_o); busy_o forwarding this cycle;
//        timeout_o one-cycle pulse when a stalled transaction is force-completed with error.
module reg_arbiter_rr
   import reg_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter type         reg_req_t      = reg_arbiter_pkg::req_default_t,
   parameter type         reg_rsp_t      = reg_arbiter_pkg::rsp_default_t,
   parameter int unsigned IDX_WIDTH      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  reg_req_t [NUM_REQ-1:0]   req_i,
   output reg_rsp_t [NUM_REQ-1:0]   rsp_o,
   output reg_req_t                 req_o,
   input  reg_rsp_t                 rsp_i,
   output logic [IDX_WIDTH-1:0]     gnt_idx_o,
   output logic                     busy_o,
   output logic                     timeout_o
);

   localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_e               state_q, state_d;
   logic [IDX_WIDTH-1:0] owner_q, owner_d, rr_q, rr_d, winner, sel;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   valid;
   logic                 any_valid, fire_to;

   always_comb
      for (int unsigned i = 0; i < NUM_REQ; i++) valid[i] = req_i[i].valid;

   reg_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_WIDTH(IDX_WIDTH)) u_pick (
      .valid_i     (valid),
      .rr_i        (rr_q),
      .any_valid_o (any_valid),
      .idx_o       (winner)
   );

   // Outputs are forced quiet while rst_ni is low, even if requesters keep valid high.
   always_comb begin
      sel       = (state_q == LOCKED) ? owner_q : winner;
      fire_to   = (TIMEOUT_CYCLES > 0) && (state_q == LOCKED) && req_i[owner_q].valid &&
                  (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES)) && !rsp_i.ready;
      req_o     = '0;
      rsp_o     = '0;
      busy_o    = 1'b0;
      timeout_o = 1'b0;
      gnt_idx_o = sel;
      state_d   = state_q;
      owner_d   = owner_q;
      rr_d      = rr_q;
      cnt_d     = cnt_q;
      if (rst_ni) begin
         if (fire_to) begin
            busy_o               = 1'b1;
            rsp_o[owner_q].ready = 1'b1;
            rsp_o[owner_q].error = 1'b1;
            timeout_o            = 1'b1;
            rr_d                 = IDX_WIDTH'(wrap_inc(32'(owner_q), NUM_REQ));
            cnt_d                = '0;
            state_d              = IDLE;
         end else if (req_i[sel].valid && (state_q == LOCKED || any_valid)) begin
            busy_o     = 1'b1;
            req_o      = req_i[sel];
            rsp_o[sel] = rsp_i;
            if (rsp_i.ready) begin
               rr_d    = IDX_WIDTH'(wrap_inc(32'(sel), NUM_REQ));
               cnt_d   = '0;
               state_d = IDLE;
            end else if (state_q == IDLE) begin
               owner_d = sel;
               cnt_d   = CNT_WIDTH'(1);
               state_d = LOCKED;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end else if (state_q == LOCKED) begin
            // Owner abandoned its transaction: release and skip past it.
            rr_d    = IDX_WIDTH'(wrap_inc(32'(owner_q), NUM_REQ));
            cnt_d   = '0;
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

   // The owner must keep valid and its payload stable until it sees ready.
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      state_q == LOCKED |-> req_i[owner_q].valid);
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == LOCKED && req_i[owner_q].valid) |-> req_i[owner_q] == $past(req_o));

endmodule

// File: tb/tb_reg_arbiter_rr.sv
module tb_reg_arbiter_rr;
   import reg_arbiter_pkg::*;

   logic                clk_i  = 1'b0;
   logic                rst_ni = 1'b0;
   req_default_t [3:0]  req_i;
   rsp_default_t [3:0]  rsp_o;
   req_default_t        req_o;
   rsp_default_t        rsp_i;
   logic [1:0]          gnt_idx_o;
   logic                busy_o, timeout_o;
   int                  checks = 0;
   int                  errors = 0;

   always #5 clk_i = ~clk_i;

   reg_arbiter_rr #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (req_i),
      .rsp_o     (rsp_o),
      .req_o     (req_o),
      .rsp_i     (rsp_i),
      .gnt_idx_o (gnt_idx_o),
      .busy_o    (busy_o),
      .timeout_o (timeout_o)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic req_default_t mk(input int i);
      return '{addr: 32'h100 + 32'(i) * 4, write: 1'b1, wdata: 32'hA000 + 32'(i), wstrb: 4'hF, valid: 1'b1};
   endfunction

   task automatic nxt;
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset;
      rst_ni = 1'b0;
      req_i  = '0;
      rsp_i  = '0;
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
   endtask

   initial begin
      req_default_t r;
      req_i    = '0;
      rsp_i    = '0;
      req_i[1] = mk(1);
      rsp_i.ready = 1'b1;
      @(negedge clk_i);
      check("rst_valid", req_o.valid, 0);
      check("rst_busy", busy_o, 0);
      check("rst_rdy1", rsp_o[1].ready, 0);
      check("rst_to", timeout_o, 0);
      check("rst_rr", dut.rr_q, 0);
      do_reset();

      // Single requester, zero-wait target
      req_i[2] = mk(2);
      rsp_i    = '{rdata: 32'hDEAD0002, error: 1'b0, ready: 1'b1};
      @(negedge clk_i);
      check("t1_req", req_o, mk(2));
      check("t1_rdy2", rsp_o[2].ready, 1);
      check("t1_rdata2", rsp_o[2].rdata, 32'hDEAD0002);
      check("t1_gnt", gnt_idx_o, 2);
      check("t1_busy", busy_o, 1);
      check("t1_rsp0", rsp_o[0], 0);
      nxt();
      check("t1_rr", dut.rr_q, 3);
      check("t1_state", dut.state_q, IDLE);

      // Two requesters, ready every cycle
      do_reset();
      req_i[0] = mk(0);
      req_i[1] = mk(1);
      rsp_i    = '{rdata: 32'h11, error: 1'b0, ready: 1'b1};
      @(negedge clk_i);
      check("t2_gnt0", gnt_idx_o, 0);
      check("t2_rdy0", rsp_o[0].ready, 1);
      check("t2_rdy1_blocked", rsp_o[1].ready, 0);
      check("t2_addr0", req_o.addr, 32'h100);
      nxt();
      req_i[0] = '0;
      @(negedge clk_i);
      check("t2_gnt1", gnt_idx_o, 1);
      check("t2_rdy1", rsp_o[1].ready, 1);
      nxt();
      req_i[1] = '0;

      // Locked grant on req 3 while req 0 waits
      req_i[3]    = mk(3);
      rsp_i.ready = 1'b0;
      @(negedge clk_i);
      check("t3_gnt_c1", gnt_idx_o, 3);
      check("t3_busy_c1", busy_o, 1);
      nxt();
      req_i[0] = mk(0);
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk_i);
         check($sformatf("t3_gnt_c%0d", k), gnt_idx_o, 3);
         check($sformatf("t3_addr_c%0d", k), req_o.addr, 32'h10C);
         check($sformatf("t3_rdy0_c%0d", k), rsp_o[0].ready, 0);
         nxt();
      end
      rsp_i.ready = 1'b1;
      @(negedge clk_i);
      check("t3_gnt_c6", gnt_idx_o, 3);
      check("t3_rdy3_c6", rsp_o[3].ready, 1);
      check("t3_rdy0_c6", rsp_o[0].ready, 0);
      nxt();
      req_i[3] = '0;
      @(negedge clk_i);
      check("t3_gnt_next", gnt_idx_o, 0);
      check("t3_rdy0_next", rsp_o[0].ready, 1);
      nxt();
      req_i[0] = '0;

      // All four requesting continuously
      do_reset();
      for (int i = 0; i < 4; i++) req_i[i] = mk(i);
      rsp_i.ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         check($sformatf("t4_gnt_%0d", i), gnt_idx_o, i % 4);
         nxt();
      end
      req_i = '0;

      // Timeout on req 1
      req_i[1] = mk(1);
      rsp_i    = '{rdata: 32'hBAD, error: 1'b0, ready: 1'b0};
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk_i);
         check($sformatf("t5_valid_c%0d", c), req_o.valid, 1);
         check($sformatf("t5_to_c%0d", c), timeout_o, 0);
         check($sformatf("t5_gnt_c%0d", c), gnt_idx_o, 1);
         nxt();
      end
      @(negedge clk_i);
      check("t5_to_pulse", timeout_o, 1);
      check("t5_rdy1", rsp_o[1].ready, 1);
      check("t5_err1", rsp_o[1].error, 1);
      check("t5_rdata1", rsp_o[1].rdata, 0);
      check("t5_valid_off", req_o.valid, 0);
      nxt();
      req_i[1]    = '0;
      req_i[0]    = mk(0);
      req_i[2]    = mk(2);
      rsp_i.ready = 1'b1;
      @(negedge clk_i);
      check("t5_rr_after", dut.rr_q, 2);
      check("t5_gnt_after", gnt_idx_o, 2);
      check("t5_to_after", timeout_o, 0);
      nxt();
      req_i = '0;
      rsp_i = '0;

      // Asynchronous reset while locked on req 2
      req_i[2] = mk(2);
      nxt();
      check("t6_locked", dut.state_q, LOCKED);
      #2 rst_ni = 1'b0;
      #1;
      check("t6_busy", busy_o, 0);
      check("t6_valid", req_o.valid, 0);
      check("t6_rdy2", rsp_o[2].ready, 0);
      check("t6_state", dut.state_q, IDLE);
      check("t6_rr", dut.rr_q, 0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      req_i[0]    = mk(0);
      rsp_i.ready = 1'b1;
      @(negedge clk_i);
      check("t6_gnt0", gnt_idx_o, 0);
      r = req_o;
      check("t6_req0", r, mk(0));
      nxt();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
